// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
// Shared pipeline types for the memory stage:
//   - MEMStageSignalsType : EX/MEM bundle consumed by mem_access_stage
//   - WBStageSignalsType  : MEM/WB bundle produced by mem_access_stage
//   - memFsmState_t       : data-memory port sequencing states
//   - FUNCT3_* constants and access-size decode helper
package mem_access_stage_pkg;

  localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
  localparam logic [2:0] FUNCT3_HALF   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD   = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
  localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

  typedef struct packed {
    logic        loadSignal;
    logic        storeSignal;
    logic [2:0]  loadStoreByteSelect;
    logic [31:0] storeData;
    logic [4:0]  rdAddr;
    logic        rdWriteEn;
    logic [1:0]  destinationSelect;
    logic [31:0] pc;
    logic [31:0] rdWriteData;
  } MEMStageSignalsType;

  typedef struct packed {
    logic [4:0]  rdAddr;
    logic        rdWriteEn;
    logic [31:0] rdWriteData;
    logic [31:0] pc;
    logic        misaligned;
  } WBStageSignalsType;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } memFsmState_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } accessSize_t;

  // Unused encodings (011/110/111) fall through to a full word access.
  function automatic accessSize_t funct3_size(input logic [2:0] funct3);
    accessSize_t size;
    case (funct3)
      FUNCT3_BYTE, FUNCT3_BYTE_U: size = SIZE_BYTE;
      FUNCT3_HALF, FUNCT3_HALF_U: size = SIZE_HALF;
      default:                    size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// load_store_align
// Purely combinational byte-lane logic for the memory stage.
// Ports:
//   funct3     in  3   access size / signedness (loadStoreByteSelect)
//   addrLo     in  2   low effective-address bits
//   storeData  in  32  register value to store (right-justified)
//   rdata      in  32  word returned by memory
//   wdata      out 32  store data replicated into every candidate lane
//   byteEn     out 4   byte enables for the addressed lanes
//   loadData   out 32  extracted and extended load result
//   misaligned out 1   access crosses its natural alignment
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLo,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  byteEn,
  output logic [31:0] loadData,
  output logic        misaligned
);

  accessSize_t size;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic        isUnsigned;

  always_comb begin
    size       = funct3_size(funct3);
    isUnsigned = funct3[2];

    misaligned = ((size == SIZE_HALF) && addrLo[0]) ||
                 ((size == SIZE_WORD) && (addrLo != 2'b00));

    case (addrLo)
      2'd0:    byteLane = rdata[7:0];
      2'd1:    byteLane = rdata[15:8];
      2'd2:    byteLane = rdata[23:16];
      default: byteLane = rdata[31:24];
    endcase
    halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SIZE_BYTE: begin
        byteEn   = 4'b0001 << addrLo;
        wdata    = {4{storeData[7:0]}};
        loadData = {{24{~isUnsigned & byteLane[7]}}, byteLane};
      end
      SIZE_HALF: begin
        byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{storeData[15:0]}};
        loadData = {{16{~isUnsigned & halfLane[15]}}, halfLane};
      end
      default: begin
        byteEn   = 4'b1111;
        wdata    = storeData;
        loadData = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage of the rv32imc pipeline. Aligns stores, extracts loads,
// sequences a valid/ready data-memory port and registers the MEM/WB bundle.
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   MEMControl        EX/MEM bundle (held stable by upstream while memStall=1)
//   memAddr           effective address from the ALU
//   dmemReqValid/Ready, dmemWe, dmemAddr, dmemWdata, dmemByteEn : request port
//   dmemRspValid, dmemRdata : load response port
//   memStall          hold EX/MEM and earlier stages
//   WBControl         registered MEM/WB bundle
//   fsmState          current port-sequencer state (observability)
//
// Handshake: a request transfers on a cycle where dmemReqValid && dmemReqReady
// are both high; once raised, dmemReqValid and the address/data/enables stay
// stable until that transfer. A load response is the single cycle where
// dmemRspValid is high while the sequencer is in WAIT_RSP; at any other time
// dmemRspValid is ignored.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  MEMStageSignalsType MEMControl,
  input  logic [ADDR_W-1:0]  memAddr,
  output logic               dmemReqValid,
  input  logic               dmemReqReady,
  output logic               dmemWe,
  output logic [ADDR_W-1:0]  dmemAddr,
  output logic [31:0]        dmemWdata,
  output logic [3:0]         dmemByteEn,
  input  logic               dmemRspValid,
  input  logic [31:0]        dmemRdata,
  output logic               memStall,
  output WBStageSignalsType  WBControl,
  output memFsmState_t       fsmState
);

  memFsmState_t      state, stateNext;
  WBStageSignalsType wbNext, wbPass;
  logic              isMem, isStore, misaligned;
  logic [31:0]       loadData;

  load_store_align u_align (
    .funct3     (MEMControl.loadStoreByteSelect),
    .addrLo     (memAddr[1:0]),
    .storeData  (MEMControl.storeData),
    .rdata      (dmemRdata),
    .wdata      (dmemWdata),
    .byteEn     (dmemByteEn),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  assign isStore  = MEMControl.storeSignal;
  assign isMem    = MEMControl.loadSignal | MEMControl.storeSignal;
  assign dmemWe   = isStore;
  assign dmemAddr = {memAddr[ADDR_W-1:2], 2'b00};
  assign fsmState = state;

  // Baseline WB image of the presented instruction; each path edits fields.
  always_comb begin
    wbPass             = '0;
    wbPass.rdAddr      = MEMControl.rdAddr;
    wbPass.rdWriteEn   = MEMControl.rdWriteEn;
    wbPass.rdWriteData = MEMControl.rdWriteData;
    wbPass.pc          = MEMControl.pc;
  end

  always_comb begin
    stateNext    = state;
    dmemReqValid = 1'b0;
    memStall     = 1'b0;
    wbNext       = '0;  // bubble unless something retires this cycle

    case (state)
      IDLE: begin
        if (!isMem) begin
          wbNext = wbPass;
        end else if (misaligned) begin
          wbNext            = wbPass;
          wbNext.rdWriteEn  = 1'b0;
          wbNext.misaligned = 1'b1;
        end else begin
          dmemReqValid = 1'b1;
          if (dmemReqReady && isStore) begin
            wbNext           = wbPass;
            wbNext.rdWriteEn = 1'b0;
          end else begin
            memStall  = 1'b1;
            stateNext = dmemReqReady ? WAIT_RSP : REQ;
          end
        end
      end

      REQ: begin
        dmemReqValid = 1'b1;
        if (dmemReqReady && isStore) begin
          wbNext           = wbPass;
          wbNext.rdWriteEn = 1'b0;
          stateNext        = IDLE;
        end else begin
          memStall = 1'b1;
          if (dmemReqReady) stateNext = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        if (dmemRspValid) begin
          wbNext             = wbPass;
          wbNext.rdWriteData = loadData;
          stateNext          = IDLE;
        end else begin
          memStall = 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase

    // Nothing may leave the stage while reset is asserted.
    if (rst) begin
      dmemReqValid = 1'b0;
      memStall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      WBControl <= '0;
    end else begin
      state     <= stateNext;
      WBControl <= wbNext;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed vectors for mem_access_stage. The driver presents one instruction
// at a time, plays the memory side (ready latency, response latency, data)
// and pushes the expected request and expected WB image into queues; a
// monitor pops and compares whenever a request handshakes or an instruction
// retires.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int WB_W = $bits(WBStageSignalsType);

  logic               clk = 1'b0;
  logic               rst;
  MEMStageSignalsType memControl;
  logic [31:0]        memAddr;
  logic               dmemReqValid, dmemReqReady, dmemWe;
  logic [31:0]        dmemAddr, dmemWdata, dmemRdata;
  logic [3:0]         dmemByteEn;
  logic               dmemRspValid, memStall;
  WBStageSignalsType  wbControl;
  memFsmState_t       fsmState;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEMControl   (memControl),
    .memAddr      (memAddr),
    .dmemReqValid (dmemReqValid),
    .dmemReqReady (dmemReqReady),
    .dmemWe       (dmemWe),
    .dmemAddr     (dmemAddr),
    .dmemWdata    (dmemWdata),
    .dmemByteEn   (dmemByteEn),
    .dmemRspValid (dmemRspValid),
    .dmemRdata    (dmemRdata),
    .memStall     (memStall),
    .WBControl    (wbControl),
    .fsmState     (fsmState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_data;
  } req_t;

  req_t            req_q[$];
  logic [WB_W-1:0] exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  logic            op_active = 1'b0;
  logic            retire_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic MEMStageSignalsType mk(input logic ld, input logic st, input logic [2:0] f3,
                                            input logic [31:0] sd, input logic [4:0] rd,
                                            input logic we, input logic [31:0] pc,
                                            input logic [31:0] rwd);
    MEMStageSignalsType c;
    c = '0;
    c.loadSignal          = ld;
    c.storeSignal         = st;
    c.loadStoreByteSelect = f3;
    c.storeData           = sd;
    c.rdAddr              = rd;
    c.rdWriteEn           = we;
    c.pc                  = pc;
    c.rdWriteData         = rwd;
    return c;
  endfunction

  task automatic push_wb(input logic [4:0] rd, input logic we, input logic [31:0] data,
                         input logic [31:0] pc, input logic mis);
    WBStageSignalsType w;
    w = '0;
    w.rdAddr      = rd;
    w.rdWriteEn   = we;
    w.rdWriteData = data;
    w.pc          = pc;
    w.misaligned  = mis;
    exp_q.push_back(w);
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic chk_data);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be; r.chk_data = chk_data;
    req_q.push_back(r);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [WB_W-1:0] e;
    req_t            r;
    forever begin
      @(negedge clk);
      if (retire_pending) begin
        retire_pending = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL wb_retire: got %h with no expected entry", wbControl);
        end else begin
          e = exp_q.pop_front();
          if (wbControl !== e) begin
            n_err++;
            $display("FAIL wb_retire: got %h expected %h", wbControl, e);
          end
        end
      end
      if (!rst && op_active && !memStall) retire_pending = 1'b1;
      if (dmemReqValid && dmemReqReady) begin
        if (req_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_req: got addr 0x%0h we %0b, required none", dmemAddr, dmemWe);
        end else begin
          r = req_q.pop_front();
          check("req_addr", dmemAddr, r.addr);
          check("req_we", {31'd0, dmemWe}, {31'd0, r.we});
          if (r.chk_data) begin
            check("req_wdata", dmemWdata, r.wdata);
            check("req_byteen", {28'd0, dmemByteEn}, {28'd0, r.be});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at #1 after a rising edge; the op stays presented on exit
  // so a following run_op issues back-to-back.
  task automatic run_op(input MEMStageSignalsType c, input logic [31:0] addr,
                        input int rdy_lat, input int rsp_lat, input logic [31:0] rdata,
                        input int exp_stall, input string name);
    int stall_cnt = 0;
    int age = 0;
    bit hs = 0;
    bit done = 0;
    memControl   = c;
    memAddr      = addr;
    op_active    = 1'b1;
    dmemRspValid = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (hs) age++;
      dmemReqReady = (cyc >= rdy_lat);
      dmemRspValid = hs && (age >= rsp_lat);
      dmemRdata    = dmemRspValid ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (dmemReqValid && dmemReqReady) begin
        hs  = 1;
        age = 0;
      end
      if (!memStall) done = 1;
      else stall_cnt++;
      @(posedge clk);
      #1;
    end
    dmemRspValid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got stall beyond 40 cycles, required completion", name);
    end
    check({name, "_stall"}, stall_cnt, exp_stall);
  endtask

  task automatic idle(input int n);
    memControl   = '0;
    memAddr      = '0;
    op_active    = 1'b0;
    dmemReqReady = 1'b0;
    dmemRspValid = 1'b0;
    dmemRdata    = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    memControl   = mk(1'b1, 1'b0, FUNCT3_WORD, 32'h0, 5'd1, 1'b1, 32'h0, 32'h0);
    memAddr      = 32'h0;
    dmemReqReady = 1'b1;
    dmemRspValid = 1'b0;
    dmemRdata    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_reqvalid", {31'd0, dmemReqValid}, 32'd0);
    check("rst_stall", {31'd0, memStall}, 32'd0);
    check("rst_state", {30'd0, fsmState}, {30'd0, IDLE});
    n_vec++;
    if (wbControl !== '0) begin
      n_err++;
      $display("FAIL rst_wb: got %h expected 0", wbControl);
    end
    @(posedge clk);
    #1;
    idle(0);
    rst = 1'b0;
    idle(1);

    // ALU passthrough
    push_wb(5'd5, 1'b1, 32'h1234_5678, 32'h80, 1'b0);
    run_op(mk(1'b0, 1'b0, FUNCT3_WORD, 32'h0, 5'd5, 1'b1, 32'h80, 32'h1234_5678),
           32'h1234_5678, 0, 0, 32'h0, 0, "alu");
    idle(1);

    // SB at 0x103
    push_req(1'b1, 32'h100, 32'hABAB_ABAB, 4'b1000, 1'b1);
    push_wb(5'd7, 1'b0, 32'h103, 32'h84, 1'b0);
    run_op(mk(1'b0, 1'b1, FUNCT3_BYTE, 32'h0000_00AB, 5'd7, 1'b1, 32'h84, 32'h103),
           32'h103, 0, 0, 32'h0, 0, "sb");
    idle(1);

    // SH at 0x2, one ready-low cycle
    push_req(1'b1, 32'h0, 32'h1234_1234, 4'b1100, 1'b1);
    push_wb(5'd0, 1'b0, 32'h2, 32'h88, 1'b0);
    run_op(mk(1'b0, 1'b1, FUNCT3_HALF, 32'h0000_1234, 5'd0, 1'b0, 32'h88, 32'h2),
           32'h2, 1, 0, 32'h0, 1, "sh");
    idle(1);

    // LH at 0x202 with wait states
    push_req(1'b0, 32'h200, 32'h0, 4'b0, 1'b0);
    push_wb(5'd10, 1'b1, 32'hFFFF_8001, 32'h8C, 1'b0);
    run_op(mk(1'b1, 1'b0, FUNCT3_HALF, 32'h0, 5'd10, 1'b1, 32'h8C, 32'h202),
           32'h202, 2, 1, 32'h8001_0000, 3, "lh");
    idle(1);

    // LHU, same timing
    push_req(1'b0, 32'h200, 32'h0, 4'b0, 1'b0);
    push_wb(5'd10, 1'b1, 32'h0000_8001, 32'h90, 1'b0);
    run_op(mk(1'b1, 1'b0, FUNCT3_HALF_U, 32'h0, 5'd10, 1'b1, 32'h90, 32'h202),
           32'h202, 2, 1, 32'h8001_0000, 3, "lhu");
    idle(1);

    // LBU at 0x1, response two cycles after handshake
    push_req(1'b0, 32'h0, 32'h0, 4'b0, 1'b0);
    push_wb(5'd11, 1'b1, 32'h0000_0080, 32'h94, 1'b0);
    run_op(mk(1'b1, 1'b0, FUNCT3_BYTE_U, 32'h0, 5'd11, 1'b1, 32'h94, 32'h1),
           32'h1, 0, 2, 32'h0000_8000, 2, "lbu");
    idle(1);

    // Misaligned LW at 0x301: no request, flagged in WB
    push_wb(5'd12, 1'b0, 32'h301, 32'h98, 1'b1);
    run_op(mk(1'b1, 1'b0, FUNCT3_WORD, 32'h0, 5'd12, 1'b1, 32'h98, 32'h301),
           32'h301, 0, 0, 32'h0, 0, "lw_mis");
    idle(1);

    // Misaligned SH at 0x1
    push_wb(5'd0, 1'b0, 32'h1, 32'h9C, 1'b1);
    run_op(mk(1'b0, 1'b1, FUNCT3_HALF, 32'h0000_BEEF, 5'd0, 1'b0, 32'h9C, 32'h1),
           32'h1, 0, 0, 32'h0, 0, "sh_mis");
    idle(1);

    // Reset while in WAIT_RSP, then a stray response
    memControl   = mk(1'b1, 1'b0, FUNCT3_WORD, 32'h0, 5'd3, 1'b1, 32'hB0, 32'h40);
    memAddr      = 32'h40;
    dmemReqReady = 1'b1;
    push_req(1'b0, 32'h40, 32'h0, 4'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rstw_state", {30'd0, fsmState}, {30'd0, WAIT_RSP});
    rst = 1'b1;
    @(negedge clk);
    check("rstw_stall", {31'd0, memStall}, 32'd0);
    check("rstw_reqvalid", {31'd0, dmemReqValid}, 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    memControl   = '0;
    memAddr      = '0;
    dmemReqReady = 1'b0;
    dmemRspValid = 1'b1;
    dmemRdata    = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstw_idle", {30'd0, fsmState}, {30'd0, IDLE});
    check("rstw_stall2", {31'd0, memStall}, 32'd0);
    n_vec++;
    if (wbControl !== '0) begin
      n_err++;
      $display("FAIL rstw_wb: got %h expected 0", wbControl);
    end
    @(posedge clk);
    #1;
    dmemRspValid = 1'b0;
    @(negedge clk);
    check("rstw_idle2", {30'd0, fsmState}, {30'd0, IDLE});
    n_vec++;
    if (wbControl !== '0) begin
      n_err++;
      $display("FAIL rstw_wb2: got %h expected 0", wbControl);
    end
    @(posedge clk);
    #1;
    idle(1);

    // Back-to-back SW 0x0 then LB 0x2
    push_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b1);
    push_wb(5'd0, 1'b0, 32'h0, 32'hA0, 1'b0);
    run_op(mk(1'b0, 1'b1, FUNCT3_WORD, 32'hCAFE_F00D, 5'd0, 1'b0, 32'hA0, 32'h0),
           32'h0, 0, 0, 32'h0, 0, "sw_b2b");
    push_req(1'b0, 32'h0, 32'h0, 4'b0, 1'b0);
    push_wb(5'd13, 1'b1, 32'hFFFF_FFFE, 32'hA4, 1'b0);
    run_op(mk(1'b1, 1'b0, FUNCT3_BYTE, 32'h0, 5'd13, 1'b1, 32'hA4, 32'h2),
           32'h2, 0, 1, 32'h00FE_0000, 1, "lb_b2b");

    // funct3 110 behaves as LW, also back-to-back
    push_req(1'b0, 32'h10, 32'h0, 4'b0, 1'b0);
    push_wb(5'd14, 1'b1, 32'h8765_4321, 32'hA8, 1'b0);
    run_op(mk(1'b1, 1'b0, 3'b110, 32'h0, 5'd14, 1'b1, 32'hA8, 32'h10),
           32'h10, 0, 1, 32'h8765_4321, 1, "lw110");
    idle(3);

    check("req_q_drained", req_q.size(), 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
